// File: rtl/oh_free_list_pkg.sv
// Shared utilities for the one-hot free list and its arbiters.
// Latency: n/a (package: constants and pure functions only).
// Backpressure: n/a.
package oh_free_list_pkg;

    // Widest vector popcount() accepts; callers zero-extend into this width.
    localparam int unsigned POP_MAXW = 1024;

    function automatic int unsigned popcount(input logic [POP_MAXW-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAXW; i++) begin
            c += {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/oh_free_list_rr_oh_select.sv
// Round-robin one-hot picker: first set bit of vec at or above ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; valid is low when vec is all zero (oh is then zero).
// Ports: vec (candidates), ptr (search start index), oh (one-hot pick), valid (|vec).
module rr_oh_select
    import oh_free_list_pkg::*;
#(
    parameter  int N  = 32,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  oh,
    output logic          valid
);

    logic [N-1:0] rot;
    logic [N-1:0] low;

    always_comb begin
        // Rotate right so index ptr lands at bit 0, isolate the lowest set
        // bit, then rotate back into the original index space.
        rot   = N'({vec, vec} >> ptr);
        low   = rot & (~rot + N'(1));
        oh    = N'(({low, low} << ptr) >> N);
        valid = |vec;
    end

endmodule

// File: rtl/oh_free_list.sv
// Bitmap free list: grants one entry per cycle as a one-hot vector, accepts bulk frees.
// Latency: grant is combinational (same cycle); frees become allocatable next cycle.
// Backpressure: alloc_gnt drops when no entry is free or during squash.
// Ports: clock/reset (sync, active-high), squash (free everything), alloc_req/alloc_gnt/
// alloc_oh (one-hot grant), free_vec (release mask), free_count/none_free/all_free (status).
// Optional: define OH_FREE_LIST_CHECK_EN to add a sticky err output (double free,
// request while empty, malformed grant vector); cleared by reset or squash.
module oh_free_list
    import oh_free_list_pkg::*;
#(
    parameter  int N  = 32,
    localparam int CW = $clog2(N) + 1,
    localparam int PW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    input  logic          alloc_req,
    output logic          alloc_gnt,
    output logic [N-1:0]  alloc_oh,
    input  logic [N-1:0]  free_vec,
    output logic [CW-1:0] free_count,
    output logic          none_free,
    output logic          all_free
`ifdef OH_FREE_LIST_CHECK_EN
    ,
    output logic          err
`endif
);

    logic [N-1:0]  free_bits_q, free_bits_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] free_count_q, free_count_d;

    logic [N-1:0]  pick_oh;
    logic          pick_vld;
    logic [PW-1:0] gnt_idx;
    logic [N-1:0]  newly_freed;

    rr_oh_select #(.N(N)) u_sel (
        .vec   (free_bits_q),
        .ptr   (ptr_q),
        .oh    (pick_oh),
        .valid (pick_vld)
    );

    assign none_free  = (free_count_q == '0);
    assign all_free   = (free_count_q == CW'(N));
    assign free_count = free_count_q;

    // The count and the bitmap agree whenever frees are legal; requiring
    // both keeps an empty bitmap from ever producing a grant.
    assign alloc_gnt = alloc_req & ~none_free & ~squash & pick_vld;
    assign alloc_oh  = alloc_gnt ? pick_oh : '0;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) gnt_idx = PW'(i);
        end
    end

    always_comb begin
        // Only releases of held entries count; double frees are absorbed.
        newly_freed  = free_vec & ~free_bits_q;
        // Clearing alloc_oh last makes the grant win over a same-cycle
        // (double) free of the granted entry.
        free_bits_d  = (free_bits_q | free_vec) & ~alloc_oh;
        free_count_d = free_count_q - CW'(alloc_gnt)
                     + CW'(popcount(POP_MAXW'(newly_freed)));
        // N is a power of two, so PW-bit overflow is the mod-N wrap.
        ptr_d        = alloc_gnt ? gnt_idx + PW'(1) : ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_bits_q  <= '1;
            ptr_q        <= '0;
            free_count_q <= CW'(N);
        end else if (squash) begin
            free_bits_q  <= '1;
            free_count_q <= CW'(N);
        end else begin
            free_bits_q  <= free_bits_d;
            ptr_q        <= ptr_d;
            free_count_q <= free_count_d;
        end
    end

`ifdef OH_FREE_LIST_CHECK_EN
    logic err_q;
    logic dbl_free;
    logic req_empty;
    logic bad_oh;

    assign dbl_free  = |(free_vec & free_bits_q);
    assign req_empty = alloc_req & none_free;
    assign bad_oh    = |(alloc_oh & (alloc_oh - N'(1)));
    assign err       = err_q;

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | dbl_free | req_empty | bad_oh;
        end
    end
`endif

endmodule

// File: tb/tb_oh_free_list.sv
// Self-checking bench for oh_free_list at N=8: directed scenarios plus a
// randomized run scored against a set-of-free-entries reference model.
module tb_oh_free_list;

    localparam int N = 8;

    logic       clock;
    logic       reset;
    logic       squash;
    logic       alloc_req;
    logic       alloc_gnt;
    logic [7:0] alloc_oh;
    logic [7:0] free_vec;
    logic [3:0] free_count;
    logic       none_free;
    logic       all_free;
`ifdef OH_FREE_LIST_CHECK_EN
    logic       err;
`endif

    int total = 0;
    int bad   = 0;

    oh_free_list #(.N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .alloc_req  (alloc_req),
        .alloc_gnt  (alloc_gnt),
        .alloc_oh   (alloc_oh),
        .free_vec   (free_vec),
        .free_count (free_count),
        .none_free  (none_free),
        .all_free   (all_free)
`ifdef OH_FREE_LIST_CHECK_EN
        ,
        .err        (err)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    bit m_free[N];
    int m_ptr;
    bit m_err;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_free[i]);
        return c;
    endfunction

    function automatic logic [7:0] m_vec();
        logic [7:0] v;
        for (int i = 0; i < N; i++) v[i] = m_free[i];
        return v;
    endfunction

    // Index the list should hand out, or -1 for no grant.
    function automatic int m_pick(input bit req, input bit sq);
        if (!req || sq || m_count() == 0) return -1;
        for (int k = 0; k < N; k++) begin
            if (m_free[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] idx2oh(input int idx);
        logic [7:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_free[i] = 1'b1;
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    task automatic m_apply(input bit req, input logic [7:0] fv, input bit sq);
        int g;
        g = m_pick(req, sq);
        if (sq) begin
            for (int i = 0; i < N; i++) m_free[i] = 1'b1;
            m_err = 1'b0;
        end else begin
            if ((fv & m_vec()) != 0 || (req && m_count() == 0)) m_err = 1'b1;
            for (int i = 0; i < N; i++) if (fv[i]) m_free[i] = 1'b1;
            if (g >= 0) begin
                m_free[g] = 1'b0;
                m_ptr = (g + 1) % N;
            end
        end
    endtask

    // ---------------- stimulus plumbing ----------------
    task automatic apply(input bit req, input logic [7:0] fv, input bit sq);
        alloc_req = req;
        free_vec  = fv;
        squash    = sq;
    endtask

    // Advance one clock, mirroring the edge into the model; returns at negedge.
    task automatic step();
        @(posedge clock);
        if (reset) m_reset();
        else m_apply(alloc_req, free_vec, squash);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(0, 8'h00, 0);
        step();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        apply(0, 8'h00, 0);
        @(negedge clock);
        step();
        step();
        reset = 1'b0;
        #1;
        total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0", alloc_gnt); end
        total++; if (alloc_oh !== 8'h00) begin bad++; $display("FAIL reset_oh: got %h want 00", alloc_oh); end
        total++; if (free_count !== 4'd8) begin bad++; $display("FAIL reset_count: got %0d want 8", free_count); end
        total++; if (none_free !== 1'b0) begin bad++; $display("FAIL reset_none: got %b want 0", none_free); end
        total++; if (all_free !== 1'b1) begin bad++; $display("FAIL reset_all: got %b want 1", all_free); end
`ifdef OH_FREE_LIST_CHECK_EN
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    endtask

    task automatic test_fill();
        apply(1, 8'h00, 0);
        for (int k = 0; k < N; k++) begin
            #1;
            total++; if (alloc_gnt !== 1'b1) begin bad++; $display("FAIL fill_gnt[%0d]: got %b want 1", k, alloc_gnt); end
            total++; if (alloc_oh !== 8'(1 << k)) begin bad++; $display("FAIL fill_oh[%0d]: got %h want %h", k, alloc_oh, 8'(1 << k)); end
            total++; if (free_count !== 4'(8 - k)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", k, free_count, 8 - k); end
            step();
        end
        #1;
        total++; if (none_free !== 1'b1) begin bad++; $display("FAIL empty_none: got %b want 1", none_free); end
        total++; if (free_count !== 4'd0) begin bad++; $display("FAIL empty_count: got %0d want 0", free_count); end
        total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL empty_gnt: got %b want 0", alloc_gnt); end
        total++; if (alloc_oh !== 8'h00) begin bad++; $display("FAIL empty_oh: got %h want 00", alloc_oh); end
        step();
        apply(0, 8'h00, 0);
    endtask

    task automatic test_free_then_alloc();
        // Empty list, ptr back at 0. The freed entries must not be grantable yet.
        apply(1, 8'h24, 0);
        #1;
        total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL nobypass_gnt: got %b want 0", alloc_gnt); end
        apply(0, 8'h24, 0);
        step();
        apply(0, 8'h00, 0);
        #1;
        total++; if (free_count !== 4'd2) begin bad++; $display("FAIL freed_count: got %0d want 2", free_count); end
        apply(1, 8'h00, 0);
        #1;
        total++; if (alloc_oh !== 8'h04) begin bad++; $display("FAIL freed_first: got %h want 04", alloc_oh); end
        step();
        #1;
        total++; if (alloc_oh !== 8'h20) begin bad++; $display("FAIL freed_second: got %h want 20", alloc_oh); end
        step();
        apply(0, 8'h00, 0);
    endtask

    task automatic test_wrap();
        int bin;
        // Empty, ptr = 6: free entries 0 and 6, grant 6 so ptr becomes 7.
        apply(0, 8'h41, 0);
        step();
        apply(1, 8'h00, 0);
        #1;
        total++; if (alloc_oh !== 8'h40) begin bad++; $display("FAIL wrap_setup: got %h want 40", alloc_oh); end
        step();
        #1;
        bin = -1;
        for (int i = 0; i < N; i++) if (alloc_oh[i]) bin = i;
        total++; if (alloc_oh !== 8'h01) begin bad++; $display("FAIL wrap_oh: got %h want 01", alloc_oh); end
        total++; if (bin != 0) begin bad++; $display("FAIL wrap_bin: got %0d want 0", bin); end
        step();
        // If ptr is now 1, entry 2 wins over entry 0.
        apply(0, 8'h05, 0);
        step();
        apply(1, 8'h00, 0);
        #1;
        total++; if (alloc_oh !== 8'h04) begin bad++; $display("FAIL wrap_ptr: got %h want 04", alloc_oh); end
        step();
        apply(0, 8'h00, 0);
    endtask

    task automatic test_alloc_and_free();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h08;
        exp_seq[1] = 8'h10;
        exp_seq[2] = 8'h80;
        do_reset();
        apply(1, 8'h00, 0);
        repeat (N) step();
        apply(0, 8'h01, 0);
        step();
        apply(1, 8'h00, 0);
        step();
        // Empty, ptr = 1; make entries 1, 3, 4 free.
        apply(0, 8'h1A, 0);
        step();
        apply(1, 8'h80, 0);
        #1;
        total++; if (alloc_oh !== 8'h02) begin bad++; $display("FAIL af_oh: got %h want 02", alloc_oh); end
        total++; if (free_count !== 4'd3) begin bad++; $display("FAIL af_count_before: got %0d want 3", free_count); end
        step();
        apply(0, 8'h00, 0);
        #1;
        total++; if (free_count !== 4'd3) begin bad++; $display("FAIL af_count_after: got %0d want 3", free_count); end
        apply(1, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (alloc_oh !== exp_seq[i]) begin bad++; $display("FAIL af_seq[%0d]: got %h want %h", i, alloc_oh, exp_seq[i]); end
            step();
        end
        #1;
        total++; if (none_free !== 1'b1) begin bad++; $display("FAIL af_drained: got %b want 1", none_free); end
        apply(0, 8'h00, 0);
    endtask

    task automatic test_double_free();
        do_reset();
        apply(0, 8'h10, 0);
        step();
        apply(0, 8'h00, 0);
        #1;
        total++; if (free_count !== 4'd8) begin bad++; $display("FAIL dbl_count: got %0d want 8", free_count); end
`ifdef OH_FREE_LIST_CHECK_EN
        total++; if (err !== 1'b1) begin bad++; $display("FAIL dbl_err: got %b want 1", err); end
`endif
        // Free the very entry being granted: the grant must win.
        apply(1, 8'h01, 0);
        #1;
        total++; if (alloc_oh !== 8'h01) begin bad++; $display("FAIL selffree_oh: got %h want 01", alloc_oh); end
        step();
        apply(0, 8'h00, 0);
        #1;
        total++; if (free_count !== 4'd7) begin bad++; $display("FAIL selffree_count: got %0d want 7", free_count); end
`ifdef OH_FREE_LIST_CHECK_EN
        apply(0, 8'h00, 1);
        step();
        apply(0, 8'h00, 0);
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_squash_clear: got %b want 0", err); end
`endif
    endtask

    task automatic test_squash();
        do_reset();
        apply(1, 8'h00, 0);
        repeat (5) step();
        #1;
        total++; if (free_count !== 4'd3) begin bad++; $display("FAIL sq_pre_count: got %0d want 3", free_count); end
        apply(1, 8'h00, 1);
        #1;
        total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL sq_gnt: got %b want 0", alloc_gnt); end
        total++; if (alloc_oh !== 8'h00) begin bad++; $display("FAIL sq_oh: got %h want 00", alloc_oh); end
        step();
        apply(0, 8'h00, 0);
        #1;
        total++; if (free_count !== 4'd8) begin bad++; $display("FAIL sq_count: got %0d want 8", free_count); end
        total++; if (all_free !== 1'b1) begin bad++; $display("FAIL sq_all: got %b want 1", all_free); end
        // ptr survived squash (5); two grants move it to 7, then reset must zero it.
        apply(1, 8'h00, 0);
        #1;
        total++; if (alloc_oh !== 8'h20) begin bad++; $display("FAIL sq_ptr_kept: got %h want 20", alloc_oh); end
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        apply(0, 8'h00, 0);
        #1;
        total++; if (free_count !== 4'd8) begin bad++; $display("FAIL rst_mid_count: got %0d want 8", free_count); end
        total++; if (all_free !== 1'b1) begin bad++; $display("FAIL rst_mid_all: got %b want 1", all_free); end
        total++; if (none_free !== 1'b0) begin bad++; $display("FAIL rst_mid_none: got %b want 0", none_free); end
        apply(1, 8'h00, 0);
        #1;
        total++; if (alloc_oh !== 8'h01) begin bad++; $display("FAIL rst_mid_ptr: got %h want 01", alloc_oh); end
        step();
        apply(0, 8'h00, 0);
    endtask

    task automatic test_random();
        bit         req;
        bit         sq;
        logic [7:0] fv;
        int         idx;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = ($urandom % 4) != 0;
            sq  = ($urandom % 25) == 0;
            if ($urandom_range(0, 9) == 0) fv = 8'($urandom);
            else fv = 8'($urandom) & 8'($urandom) & ~m_vec();
            apply(req, fv, sq);
            #1;
            idx = m_pick(req, sq);
            total++; if (alloc_gnt !== (idx >= 0)) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, alloc_gnt, idx >= 0); end
            total++; if (alloc_oh !== idx2oh(idx)) begin bad++; $display("FAIL rnd_oh[%0d]: got %h want %h", c, alloc_oh, idx2oh(idx)); end
            total++; if (free_count !== 4'(m_count())) begin bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, free_count, m_count()); end
            total++; if (none_free !== (m_count() == 0)) begin bad++; $display("FAIL rnd_none[%0d]: got %b", c, none_free); end
            total++; if (all_free !== (m_count() == N)) begin bad++; $display("FAIL rnd_all[%0d]: got %b", c, all_free); end
`ifdef OH_FREE_LIST_CHECK_EN
            total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b want %b", c, err, m_err); end
`endif
            step();
        end
        apply(0, 8'h00, 0);
    endtask

    initial begin
        m_reset();
        test_reset();
        test_fill();
        test_free_then_alloc();
        test_wrap();
        test_alloc_and_free();
        test_double_free();
        test_squash();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
